// File: rtl/base_multicycle_demux.sv
// base_multicycle_demux: pipelined tree demultiplexer steering one valid/data
// stream to one of `ways` lanes through `stages` levels of stage_ways-way nodes.
//   clk    : clock
//   reset  : synchronous active-high reset (clears valid/select/error state)
//   i_v    : transfer request, leads i_d by one cycle when early_valid=1
//   i_sel  : destination lane index, sampled with i_v
//   i_d    : transfer data
//   o_v    : one-hot lane valid, fixed latency of `stages` cycles
//   o_d    : per-lane data, lane k in bits [k*width +: width]
//   o_err  : one-cycle pulse when a request was dropped for i_sel >= ways
module base_multicycle_demux #(
   parameter int width       = 1,
   parameter int stages      = 1,
   parameter int early_valid = 1,
   parameter int stage_ways  = 4,
   parameter int ways        = stage_ways ** stages,
   parameter int selw        = ((stage_ways ** stages) > 1) ? $clog2(stage_ways ** stages) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_v,
   input  logic [selw-1:0]        i_sel,
   input  logic [width-1:0]       i_d,
   output logic [ways-1:0]        o_v,
   output logic [ways*width-1:0]  o_d,
   output logic                   o_err
);
   function automatic int pw(input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r *= stage_ways;
      return r;
   endfunction
   // flat node numbering: level j occupies [off(j), off(j+1))
   function automatic int off(input int j);
      int o = 0;
      for (int i = 1; i <= j; i++) o += pw(i);
      return o;
   endfunction
   localparam int nodes = off(stages);
   localparam int leaf0 = off(stages - 1);
   logic                v  [nodes];
   logic                vn [nodes];
   logic [selw-1:0]     s  [nodes];
   logic [selw-1:0]     sn [nodes];
   logic [width-1:0]    d  [nodes];
   logic [width-1:0]    ds [nodes];
   logic [stages-1:0]   e;
   logic                in_range;
   assign in_range = int'(i_sel) < ways;
   // out-of-range requests never enter the tree; they ride a plain delay line
   always_ff @(posedge clk)
      e <= reset ? '0 : stages'({e, i_v & ~in_range});
   assign o_err = e[stages-1];
   // each node takes its parent's valid when the parent's digit matches its own
   // position; the full select is carried along and each level picks its digit
   always_comb begin
      int p;
      int dig;
      logic pv;
      logic [selw-1:0] ps;
      logic [width-1:0] pd;
      p = 0;
      dig = 0;
      pv = 1'b0;
      ps = '0;
      pd = '0;
      for (int i = 0; i < nodes; i++) begin
         vn[i] = 1'b0;
         sn[i] = '0;
         ds[i] = '0;
      end
      for (int j = 0; j < stages; j++)
         for (int n = 0; n < pw(j + 1); n++) begin
            p = off(j - 1) + n / stage_ways;
            pv = (j == 0) ? (i_v & in_range) : v[p];
            ps = (j == 0) ? i_sel : s[p];
            pd = (j == 0) ? i_d : d[p];
            dig = (int'(ps) / pw(stages - 1 - j)) % stage_ways;
            vn[off(j) + n] = pv && (dig == n % stage_ways);
            sn[off(j) + n] = ps;
            ds[off(j) + n] = pd;
         end
   end
   for (genvar i = 0; i < nodes; i++) begin : g_node
      always_ff @(posedge clk) begin
         v[i] <= reset ? 1'b0 : vn[i];
         s[i] <= reset ? '0 : sn[i];
      end
      // data trails valid by early_valid cycles, so load off the registered
      // valid (early) or the valid being captured this edge (aligned)
      always_ff @(posedge clk)
         if ((early_valid != 0) ? v[i] : (vn[i] && !reset))
            d[i] <= ds[i];
   end
   for (genvar k = 0; k < ways; k++) begin : g_lane
      assign o_v[k] = v[leaf0 + k];
      assign o_d[k*width +: width] = d[leaf0 + k];
   end
endmodule

// File: tb/tb_base_multicycle_demux.sv
// tb_base_multicycle_demux: scoreboard bench over four demux configurations
module tb_base_multicycle_demux;
   typedef struct {
      int inst;
      int due;
      int kind;
      int lane;
      logic [7:0] dat;
   } ent_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int stg [4] = '{2, 2, 2, 1};
   int evs [4] = '{1, 1, 0, 1};
   int nw  [4] = '{16, 13, 16, 4};
   logic [3:0]   iv = '0;
   logic [3:0]   isel [4];
   logic [7:0]   id [4];
   logic [15:0]  ov0, ov2;
   logic [12:0]  ov1;
   logic [3:0]   ov3;
   logic [127:0] od0, od2;
   logic [103:0] od1;
   logic [31:0]  od3;
   logic [3:0]   oe;
   base_multicycle_demux #(.width(8), .stages(2), .early_valid(1), .stage_ways(4), .ways(16)) u_a (
      .clk(clk), .reset(reset), .i_v(iv[0]), .i_sel(isel[0]), .i_d(id[0]), .o_v(ov0), .o_d(od0), .o_err(oe[0]));
   base_multicycle_demux #(.width(8), .stages(2), .early_valid(1), .stage_ways(4), .ways(13)) u_b (
      .clk(clk), .reset(reset), .i_v(iv[1]), .i_sel(isel[1]), .i_d(id[1]), .o_v(ov1), .o_d(od1), .o_err(oe[1]));
   base_multicycle_demux #(.width(8), .stages(2), .early_valid(0), .stage_ways(4), .ways(16)) u_c (
      .clk(clk), .reset(reset), .i_v(iv[2]), .i_sel(isel[2]), .i_d(id[2]), .o_v(ov2), .o_d(od2), .o_err(oe[2]));
   base_multicycle_demux #(.width(8), .stages(1), .early_valid(1), .stage_ways(4), .ways(4)) u_d (
      .clk(clk), .reset(reset), .i_v(iv[3]), .i_sel(isel[3][1:0]), .i_d(id[3]), .o_v(ov3), .o_d(od3), .o_err(oe[3]));
   ent_t q [$];
   logic [7:0] mdl [4][16];
   bit known [4][16];
   bit chk_en = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   bit nv [4];
   int nsel [4];
   logic [7:0] ndat [4];
   logic [7:0] pend [4];
   bit nrst = 1'b1;
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask
   function automatic logic [15:0] get_ov(input int i);
      case (i)
         0: return ov0;
         1: return {3'b0, ov1};
         2: return ov2;
         default: return {12'b0, ov3};
      endcase
   endfunction
   function automatic logic [127:0] get_od(input int i);
      case (i)
         0: return od0;
         1: return {24'b0, od1};
         2: return od2;
         default: return {96'b0, od3};
      endcase
   endfunction
   task automatic req(input int i, input int sel, input logic [7:0] dat);
      nv[i] = 1'b1;
      nsel[i] = sel;
      ndat[i] = dat;
   endtask
   // one clock: apply the staged requests, push their expected outcomes
   task automatic step();
      @(posedge clk);
      #1;
      reset = nrst;
      for (int i = 0; i < 4; i++) begin
         iv[i] = nv[i];
         isel[i] = 4'(nsel[i]);
         id[i] = (evs[i] != 0) ? pend[i] : ndat[i];
         pend[i] = ndat[i];
         if (nv[i]) begin
            if (nsel[i] >= nw[i]) q.push_back('{i, cyc + stg[i], 1, 0, 8'h0});
            else begin
               q.push_back('{i, cyc + stg[i], 0, nsel[i], ndat[i]});
               q.push_back('{i, cyc + stg[i] + evs[i], 2, nsel[i], ndat[i]});
            end
         end
         nv[i] = 1'b0;
         ndat[i] = 8'($urandom);
      end
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask
   always @(negedge clk) if (chk_en) begin : check_blk
      logic [15:0] eov [4];
      logic eerr [4];
      logic [127:0] odv;
      for (int i = 0; i < 4; i++) begin
         eov[i] = '0;
         eerr[i] = 1'b0;
      end
      for (int k = q.size() - 1; k >= 0; k--)
         if (q[k].due == cyc) begin
            if (q[k].kind == 0) eov[q[k].inst][q[k].lane] = 1'b1;
            else if (q[k].kind == 1) eerr[q[k].inst] = 1'b1;
            else begin
               mdl[q[k].inst][q[k].lane] = q[k].dat;
               known[q[k].inst][q[k].lane] = 1'b1;
            end
            q.delete(k);
         end
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("u%0d_o_v", i), 128'(get_ov(i)), 128'(eov[i]));
         chk($sformatf("u%0d_o_err", i), 128'(oe[i]), 128'(eerr[i]));
         odv = get_od(i);
         for (int k = 0; k < nw[i]; k++)
            if (known[i][k]) chk($sformatf("u%0d_lane%0d", i, k), 128'(odv[k*8 +: 8]), 128'(mdl[i][k]));
      end
      // reset discards everything in flight; lanes it targeted may still load
      if (reset) begin
         foreach (q[k]) if (q[k].kind != 1) known[q[k].inst][q[k].lane] = 1'b0;
         q.delete();
      end
   end
   initial begin
      for (int i = 0; i < 4; i++) begin
         isel[i] = '0;
         id[i] = '0;
         pend[i] = '0;
         ndat[i] = '0;
         nv[i] = 1'b0;
         nsel[i] = 0;
         for (int k = 0; k < 16; k++) known[i][k] = 1'b0;
      end
      step();
      chk_en = 1'b1;
      idle(2);
      nrst = 1'b0;
      idle(3);
      req(0, 9, 8'hA5);
      step();
      idle(5);
      req(0, 0, 8'h11);
      step();
      req(0, 15, 8'h22);
      step();
      req(0, 0, 8'h33);
      step();
      req(0, 7, 8'h44);
      step();
      idle(5);
      req(1, 14, 8'h5C);
      step();
      idle(4);
      req(1, 12, 8'hC3);
      step();
      req(1, 13, 8'h99);
      step();
      req(1, 15, 8'h98);
      step();
      idle(4);
      req(2, 3, 8'h7E);
      step();
      req(2, 3, 8'h81);
      step();
      idle(4);
      req(0, 5, 8'h5A);
      step();
      nrst = 1'b1;
      step();
      nrst = 1'b0;
      idle(5);
      req(0, 5, 8'h66);
      step();
      idle(5);
      for (int c = 0; c < 1000; c++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 3) != 0)
               req(i, (i == 3) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)), 8'($urandom));
         step();
      end
      idle(6);
      chk("drain", 128'(q.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
